multicycle_ctrl_fsm: RTL and testbench

//  Control FSM for the multicycle RV32I core. Sequences the shared ALU, single memory port,

---
 rtl/riscv_ctrl_pkg.sv | 139 +++++++++++++
 rtl/multicycle_ctrl_fsm_if.sv | 31 +++
 rtl/ctrl_instr_dec.sv | 28 ++
 rtl/multicycle_ctrl_fsm.sv | 95 +++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multicycle control FSM
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_NOP    = 7'b0000000;

    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RD1      = 2'b10;
    localparam logic [1:0] SRCB_RD2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] ALUOP_ADD     = 2'b00;
    localparam logic [1:0] ALUOP_SUB     = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT   = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_rtype;
        logic is_itype;
        logic is_branch;
        logic is_jal;
        logic is_nop;
    } op_class_t;

    // Per-state Moore controls; fetch/branch/pc_update are raw flags that get qualified later
    typedef struct packed {
        logic       fetch;
        logic       mem_req;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        logic       pc_update;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.mem_req    = 1'b1;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALURESULT;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            S_MEMREAD: begin
                c.mem_req    = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req    = 1'b1;
                c.mem_write  = 1'b1;
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_RD2;
                c.alu_op     = ALUOP_SUB;
                c.result_src = RES_ALUOUT;
                c.branch     = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.alu_op     = ALUOP_ADD;
                c.result_src = RES_ALUOUT;
                c.pc_update  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - control bundle between the multicycle FSM and the datapath/memory
interface multicycle_ctrl_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       illegal_op;
    logic       mem_timeout;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal_op, mem_timeout
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, adr_src, ir_write, pc_write, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, alu_op, imm_src, illegal_op, mem_timeout
    );
endinterface

// File: rtl/ctrl_instr_dec.sv
// rtl/ctrl_instr_dec.sv - opcode classifier and immediate-format select
module ctrl_instr_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src,
    output op_class_t  cls,
    output logic       illegal
);

    // One-hot opcode class plus immediate format; anything unlisted is illegal
    always_comb begin
        cls     = '0;
        imm_src = IMM_I;
        case (op)
            OP_LOAD:   cls.is_load = 1'b1;
            OP_STORE:  begin cls.is_store  = 1'b1; imm_src = IMM_S; end
            OP_RTYPE:  cls.is_rtype = 1'b1;
            OP_ITYPE:  cls.is_itype = 1'b1;
            OP_BRANCH: begin cls.is_branch = 1'b1; imm_src = IMM_B; end
            OP_JAL:    begin cls.is_jal    = 1'b1; imm_src = IMM_J; end
            OP_NOP:    cls.is_nop = 1'b1;
            default:   cls = '0;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - fetch/decode/execute/writeback sequencer for the multicycle RV32I core
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_ctrl_fsm_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t         state;
    state_t         state_nxt;
    ctrl_t          ctrl_q;
    logic [CW-1:0]  wait_cnt;
    logic           waiting;
    logic           timeout_hit;
    logic           live;
    logic           fetch_done;
    op_class_t      cls;
    logic           dec_illegal;
    logic [2:0]     dec_imm;

    ctrl_instr_dec u_dec (
        .op      (bus.op),
        .imm_src (dec_imm),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    // Next-state selection; an expired memory wait overrides everything and retries the fetch
    always_comb begin
        waiting     = ctrl_q.mem_req & ~bus.mem_ready;
        timeout_hit = waiting && (wait_cnt == CNT_LAST);
        state_nxt   = state;
        case (state)
            S_FETCH:    if (bus.mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                if (cls.is_nop || dec_illegal)        state_nxt = S_FETCH;
                else if (cls.is_load || cls.is_store) state_nxt = S_MEMADR;
                else if (cls.is_rtype)                state_nxt = S_EXECR;
                else if (cls.is_itype)                state_nxt = S_EXECI;
                else if (cls.is_branch)               state_nxt = S_BEQ;
                else                                  state_nxt = S_JAL;
            end
            S_MEMADR:   state_nxt = cls.is_store ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (bus.mem_ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (bus.mem_ready) state_nxt = S_FETCH;
            S_EXECR:    state_nxt = S_ALUWB;
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BEQ:      state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            default:    state_nxt = S_FETCH;
        endcase
        if (timeout_hit) state_nxt = S_FETCH;
    end

    // State, registered Moore controls for that state, and the memory wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            ctrl_q   <= state_ctrl(S_FETCH);
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ctrl_q   <= state_ctrl(state_nxt);
            wait_cnt <= (waiting && !timeout_hit) ? wait_cnt + CW'(1) : '0;
        end
    end

    // Strobes are masked during reset; mux selects fall back to FETCH values
    always_comb begin
        live            = ~reset;
        fetch_done      = live & ctrl_q.fetch & bus.mem_ready;
        bus.mem_req     = live & ctrl_q.mem_req;
        bus.mem_write   = live & ctrl_q.mem_write;
        bus.reg_write   = live & ctrl_q.reg_write;
        bus.ir_write    = fetch_done;
        bus.pc_write    = fetch_done | (live & ((ctrl_q.branch & bus.zero) | ctrl_q.pc_update));
        bus.illegal_op  = live & (state == S_DECODE) & dec_illegal;
        bus.mem_timeout = live & timeout_hit;
        bus.adr_src     = reset ? 1'b0          : ctrl_q.adr_src;
        bus.alu_src_a   = reset ? SRCA_PC       : ctrl_q.alu_src_a;
        bus.alu_src_b   = reset ? SRCB_FOUR     : ctrl_q.alu_src_b;
        bus.result_src  = reset ? RES_ALURESULT : ctrl_q.result_src;
        bus.alu_op      = reset ? ALUOP_ADD     : ctrl_q.alu_op;
        bus.imm_src     = dec_imm;
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed scoreboard bench for the multicycle control FSM
module tb_multicycle_ctrl_fsm;

    typedef enum int {
        T_RESET, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
        T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL
    } tst_t;

    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] ITY  = 7'b0010011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] NOP  = 7'b0000000;
    localparam logic [6:0] BAD  = 7'b1111111;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    logic [18:0] sb[$];

    multicycle_ctrl_fsm_if bus();

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Expected outputs for the state the bench believes the DUT is in
    function automatic logic [18:0] exp_out(tst_t s, logic [6:0] o, logic z, logic r,
                                            logic ill, logic to);
        logic mr, ad, ir, pw, mw, rw;
        logic [1:0] a, b, rs, al;
        logic [2:0] imm;
        {mr, ad, ir, pw, mw, rw} = '0;
        {a, b, rs, al} = '0;
        case (s)
            T_RESET:    begin b = 2'b10; rs = 2'b10; end
            T_FETCH:    begin mr = 1'b1; ir = r; pw = r; b = 2'b10; rs = 2'b10; end
            T_DECODE:   begin a = 2'b01; b = 2'b01; end
            T_MEMADR:   begin a = 2'b10; b = 2'b01; end
            T_MEMREAD:  begin mr = 1'b1; ad = 1'b1; end
            T_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            T_MEMWRITE: begin mr = 1'b1; mw = 1'b1; ad = 1'b1; end
            T_EXECR:    begin a = 2'b10; al = 2'b10; end
            T_EXECI:    begin a = 2'b10; b = 2'b01; al = 2'b10; end
            T_ALUWB:    rw = 1'b1;
            T_BEQ:      begin a = 2'b10; al = 2'b01; pw = z; end
            T_JAL:      begin a = 2'b01; b = 2'b10; pw = 1'b1; end
            default:    ;
        endcase
        case (o)
            SW:      imm = 3'b001;
            BEQ:     imm = 3'b010;
            JAL:     imm = 3'b011;
            default: imm = 3'b000;
        endcase
        return {mr, ad, ir, pw, mw, rw, ill, to, a, b, rs, al, imm};
    endfunction

    task automatic cyc(input tst_t s, input logic [6:0] o, input logic z, input logic r,
                       input logic ill, input logic to, input string tag);
        logic [18:0] got;
        logic [18:0] e;
        @(negedge clk);
        reset = (s == T_RESET);
        bus.op = o;
        bus.zero = z;
        bus.mem_ready = r;
        sb.push_back(exp_out(s, o, z, r, ill, to));
        #1;
        got = {bus.mem_req, bus.adr_src, bus.ir_write, bus.pc_write, bus.mem_write,
               bus.reg_write, bus.illegal_op, bus.mem_timeout, bus.alu_src_a, bus.alu_src_b,
               bus.result_src, bus.alu_op, bus.imm_src};
        e = sb.pop_front();
        n_tests++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, got, e);
        end
    endtask

    initial begin
        bus.op = NOP;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b1;

        // reset with memory claiming ready
        cyc(T_RESET, NOP, 0, 1, 0, 0, "rst0");
        cyc(T_RESET, NOP, 0, 1, 0, 0, "rst1");
        cyc(T_RESET, NOP, 0, 1, 0, 0, "rst2");
        cyc(T_FETCH, NOP, 0, 0, 0, 0, "post_rst_fetch");

        // R-type, zero-wait memory
        cyc(T_FETCH,  RTY, 0, 1, 0, 0, "r_fetch");
        cyc(T_DECODE, RTY, 0, 1, 0, 0, "r_decode");
        cyc(T_EXECR,  RTY, 0, 1, 0, 0, "r_exec");
        cyc(T_ALUWB,  RTY, 0, 1, 0, 0, "r_wb");

        // lw with two wait cycles in MEMREAD
        cyc(T_FETCH,   LW, 0, 1, 0, 0, "lw_fetch");
        cyc(T_DECODE,  LW, 0, 1, 0, 0, "lw_decode");
        cyc(T_MEMADR,  LW, 0, 1, 0, 0, "lw_memadr");
        cyc(T_MEMREAD, LW, 0, 0, 0, 0, "lw_wait0");
        cyc(T_MEMREAD, LW, 0, 0, 0, 0, "lw_wait1");
        cyc(T_MEMREAD, LW, 0, 1, 0, 0, "lw_ready");
        cyc(T_MEMWB,   LW, 0, 0, 0, 0, "lw_wb");

        // beq taken and not taken
        cyc(T_FETCH,  BEQ, 1, 1, 0, 0, "beq1_fetch");
        cyc(T_DECODE, BEQ, 1, 1, 0, 0, "beq1_decode");
        cyc(T_BEQ,    BEQ, 1, 1, 0, 0, "beq_taken");
        cyc(T_FETCH,  BEQ, 0, 1, 0, 0, "beq0_fetch");
        cyc(T_DECODE, BEQ, 0, 1, 0, 0, "beq0_decode");
        cyc(T_BEQ,    BEQ, 0, 1, 0, 0, "beq_not_taken");

        // illegal opcode, then NOP
        cyc(T_FETCH,  BAD, 0, 1, 0, 0, "bad_fetch");
        cyc(T_DECODE, BAD, 0, 1, 1, 0, "bad_decode");
        cyc(T_FETCH,  NOP, 0, 1, 0, 0, "nop_fetch");
        cyc(T_DECODE, NOP, 0, 1, 0, 0, "nop_decode");

        // I-type and jal
        cyc(T_FETCH,  ITY, 0, 1, 0, 0, "i_fetch");
        cyc(T_DECODE, ITY, 0, 1, 0, 0, "i_decode");
        cyc(T_EXECI,  ITY, 0, 1, 0, 0, "i_exec");
        cyc(T_ALUWB,  ITY, 0, 1, 0, 0, "i_wb");
        cyc(T_FETCH,  JAL, 0, 1, 0, 0, "jal_fetch");
        cyc(T_DECODE, JAL, 0, 1, 0, 0, "jal_decode");
        cyc(T_JAL,    JAL, 0, 1, 0, 0, "jal_exec");
        cyc(T_ALUWB,  JAL, 0, 1, 0, 0, "jal_wb");

        // sw completing normally
        cyc(T_FETCH,    SW, 0, 1, 0, 0, "sw_fetch");
        cyc(T_DECODE,   SW, 0, 1, 0, 0, "sw_decode");
        cyc(T_MEMADR,   SW, 0, 1, 0, 0, "sw_memadr");
        cyc(T_MEMWRITE, SW, 0, 1, 0, 0, "sw_write");

        // sw with memory stuck: timeout on the 4th wait cycle
        cyc(T_FETCH,    SW, 0, 1, 0, 0, "swto_fetch");
        cyc(T_DECODE,   SW, 0, 1, 0, 0, "swto_decode");
        cyc(T_MEMADR,   SW, 0, 1, 0, 0, "swto_memadr");
        cyc(T_MEMWRITE, SW, 0, 0, 0, 0, "swto_wait1");
        cyc(T_MEMWRITE, SW, 0, 0, 0, 0, "swto_wait2");
        cyc(T_MEMWRITE, SW, 0, 0, 0, 0, "swto_wait3");
        cyc(T_MEMWRITE, SW, 0, 0, 0, 1, "swto_timeout");

        // fetch stuck: timeout without ir/pc update, then retry succeeds
        cyc(T_FETCH,  NOP, 0, 0, 0, 0, "fto_wait1");
        cyc(T_FETCH,  NOP, 0, 0, 0, 0, "fto_wait2");
        cyc(T_FETCH,  NOP, 0, 0, 0, 0, "fto_wait3");
        cyc(T_FETCH,  NOP, 0, 0, 0, 1, "fto_timeout");
        cyc(T_FETCH,  NOP, 0, 1, 0, 0, "fto_retry");
        cyc(T_DECODE, NOP, 0, 1, 0, 0, "fto_decode");

        // reset in the middle of a store
        cyc(T_FETCH,    SW, 0, 1, 0, 0, "swrst_fetch");
        cyc(T_DECODE,   SW, 0, 1, 0, 0, "swrst_decode");
        cyc(T_MEMADR,   SW, 0, 1, 0, 0, "swrst_memadr");
        cyc(T_MEMWRITE, SW, 0, 0, 0, 0, "swrst_wait");
        cyc(T_RESET,    SW, 0, 1, 0, 0, "swrst_reset");
        cyc(T_FETCH,    SW, 0, 0, 0, 0, "swrst_fetch_after");
        cyc(T_FETCH,    SW, 0, 0, 0, 0, "swrst_cnt_clear1");
        cyc(T_FETCH,    SW, 0, 0, 0, 0, "swrst_cnt_clear2");
        cyc(T_FETCH,    SW, 0, 1, 0, 0, "swrst_fetch_done");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
